digit_vote_display: RTL and testbench

- Consumes the 4-bit digit class produced by the perceptron classifier stage, one sample per valid handshake.
- Accumulates a histogram over a window of WINDOW samples, then selects the most frequent digit (majority vote).
- Drives a 7-segment display and a registered result interface with the winning digit and its vote count.
- Suppresses single-frame misclassifications before the result reaches the chip outputs.

---
 rtl/digit_vote_display.sv | 145 ++++++++++++++
 tb/tb_digit_vote_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/digit_vote_display.sv
// Majority-vote filter for the digit classifier: collects a window of class samples,
// scans the histogram for the winner and drives a 7-segment digit plus a result strobe.
// Optional confidence indicator on dp is enabled by defining VOTE_CONFIDENCE_EN.
module digit_vote_display #(
   parameter int WINDOW      = 8,
   parameter int CONF_THRESH = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_class,
   output logic [3:0] result_digit,
   output logic [7:0] result_count,
   output logic       result_pulse,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] LAST_SAMPLE = CW'(WINDOW - 1);

   if (WINDOW < 2 || WINDOW > 255) begin : gWindowCheck
      $error("digit_vote_display: WINDOW must be 2..255");
   end
   if (CONF_THRESH < 0) begin : gThreshCheck
      $error("digit_vote_display: CONF_THRESH must be non-negative");
   end

   typedef enum logic [1:0] {
      COLLECT,
      SCAN,
      PRESENT
   } voteState_t;

   voteState_t state_q, state_d;

   logic [CW-1:0] bins_q [10];
   logic [CW-1:0] sampleCnt_q;
   logic [3:0]    scanIdx_q;
   logic [CW-1:0] bestCount_q;
   logic [3:0]    bestIdx_q;
   logic [3:0]    resultDigit_q;
   logic [7:0]    resultCount_q;
   logic          resultPulse_q;
   logic [6:0]    seg_q;
   logic          dp_q;
   logic          accept;

   function automatic logic [6:0] segEncode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'h3F;
         4'd1:    pattern = 7'h06;
         4'd2:    pattern = 7'h5B;
         4'd3:    pattern = 7'h4F;
         4'd4:    pattern = 7'h66;
         4'd5:    pattern = 7'h6D;
         4'd6:    pattern = 7'h7D;
         4'd7:    pattern = 7'h07;
         4'd8:    pattern = 7'h7F;
         4'd9:    pattern = 7'h6F;
         default: pattern = 7'h40;
      endcase
      return pattern;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= COLLECT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (accept && sampleCnt_q == LAST_SAMPLE) state_d = SCAN;
         SCAN:    if (scanIdx_q == 4'd9) state_d = PRESENT;
         PRESENT: state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      in_ready = (state_q == COLLECT) && !rst;
   end

   assign accept = in_valid && in_ready;

   // Histogram, strict-greater scan (ties keep the lowest digit) and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 10; k++) bins_q[k] <= '0;
         sampleCnt_q   <= '0;
         scanIdx_q     <= '0;
         bestCount_q   <= '0;
         bestIdx_q     <= 4'hF;
         resultDigit_q <= '0;
         resultCount_q <= '0;
         resultPulse_q <= 1'b0;
         seg_q         <= 7'h00;
         dp_q          <= 1'b0;
      end else begin
         resultPulse_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  sampleCnt_q <= sampleCnt_q + 1'b1;
                  if (in_class <= 4'd9) bins_q[in_class] <= bins_q[in_class] + 1'b1;
               end
            end
            SCAN: begin
               if (bins_q[scanIdx_q] > bestCount_q) begin
                  bestCount_q <= bins_q[scanIdx_q];
                  bestIdx_q   <= scanIdx_q;
               end
               scanIdx_q <= scanIdx_q + 1'b1;
            end
            PRESENT: begin
               resultDigit_q <= bestIdx_q;
               resultCount_q <= 8'(bestCount_q);
               resultPulse_q <= 1'b1;
               seg_q         <= segEncode(bestIdx_q);
`ifdef VOTE_CONFIDENCE_EN
               dp_q          <= (32'(bestCount_q) >= CONF_THRESH);
`else
               dp_q          <= 1'b0;
`endif
               for (int k = 0; k < 10; k++) bins_q[k] <= '0;
               sampleCnt_q <= '0;
               scanIdx_q   <= '0;
               bestCount_q <= '0;
               bestIdx_q   <= 4'hF;
            end
            default: ;
         endcase
      end
   end

   assign result_digit = resultDigit_q;
   assign result_count = resultCount_q;
   assign result_pulse = resultPulse_q;
   assign seg          = seg_q;
   assign dp           = dp_q;

endmodule

// File: tb/tb_digit_vote_display.sv
// Directed bench for digit_vote_display: fixed windows with hand-computed winners,
// latency/throughput under continuous valid, and mid-window reset.
module tb_digit_vote_display;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_class;
   logic [3:0] result_digit;
   logic [7:0] result_count;
   logic       result_pulse;
   logic [6:0] seg;
   logic       dp;

   int vecCount  = 0;
   int missCount = 0;

`ifdef VOTE_CONFIDENCE_EN
   localparam logic CONF_DP = 1'b1;
`else
   localparam logic CONF_DP = 1'b0;
`endif

   digit_vote_display #(.WINDOW(8), .CONF_THRESH(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_class     (in_class),
      .result_digit (result_digit),
      .result_count (result_count),
      .result_pulse (result_pulse),
      .seg          (seg),
      .dp           (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, " rst digit"}, 32'(result_digit), 32'd0);
      checkOutput({tag, " rst count"}, 32'(result_count), 32'd0);
      checkOutput({tag, " rst pulse"}, 32'(result_pulse), 32'd0);
      checkOutput({tag, " rst seg"},   32'(seg),          32'h00);
      checkOutput({tag, " rst dp"},    32'(dp),           32'd0);
      checkOutput({tag, " rst ready"}, 32'(in_ready),     32'd0);
      rst = 1'b0;
   endtask

   // Presents one sample and returns just after the edge that accepts it.
   task automatic applyStimulus(input logic [3:0] cls);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("ready timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_class = cls;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Sends eight classes (nibble 0 first) and checks latency, outputs and pulse width.
   task automatic runWindow(input string tag, input logic [31:0] classes,
                            input logic [3:0] expDigit, input logic [7:0] expCount,
                            input logic [6:0] expSeg, input logic expDp);
      int lat = 0;
      logic [31:0] shifted;
      shifted = classes;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(shifted[3:0]);
         shifted = shifted >> 4;
      end
      @(negedge clk);
      checkOutput({tag, " ready low"}, 32'(in_ready), 32'd0);
      lat = 1;
      while (!result_pulse && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, " latency"}, 32'(lat),          32'd12);
      checkOutput({tag, " digit"},   32'(result_digit), 32'(expDigit));
      checkOutput({tag, " count"},   32'(result_count), 32'(expCount));
      checkOutput({tag, " seg"},     32'(seg),          32'(expSeg));
      checkOutput({tag, " dp"},      32'(dp),           32'(expDp));
      checkOutput({tag, " ready"},   32'(in_ready),     32'd1);
      @(negedge clk);
      checkOutput({tag, " pulse width"}, 32'(result_pulse), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput({tag, " seg hold"},   32'(seg),          32'(expSeg));
      checkOutput({tag, " digit hold"}, 32'(result_digit), 32'(expDigit));
   endtask

   // Holds valid with class 4 and checks the 19-cycle result cadence.
   task automatic runStreaming();
      int cycle = 0;
      int lastPulse = -1;
      int lowRun = 0;
      int pulses = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_class = 4'd4;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         cycle = n;
         if (!in_ready) lowRun++;
         else if (lowRun != 0) begin
            checkOutput("stream ready-low run", 32'(lowRun), 32'd11);
            lowRun = 0;
         end
         if (result_pulse) begin
            pulses++;
            checkOutput("stream digit", 32'(result_digit), 32'd4);
            checkOutput("stream count", 32'(result_count), 32'd8);
            if (lastPulse >= 0) checkOutput("stream period", 32'(cycle - lastPulse), 32'd19);
            else                checkOutput("stream first pulse", 32'(cycle), 32'd19);
            lastPulse = cycle;
         end
      end
      checkOutput("stream pulse count", 32'(pulses), 32'd3);
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_class = 4'd0;

      doReset("initial");
      runWindow("all3",    32'h3333_3333, 4'd3,  8'd8, 7'h4F, CONF_DP);
      runWindow("tie2",    32'h1722_2555, 4'd2,  8'd3, 7'h5B, 1'b0);
      runWindow("invalid", 32'hCCCC_CCCC, 4'hF,  8'd0, 7'h40, 1'b0);
      runWindow("tie0",    32'h0FA1_1100, 4'd0,  8'd3, 7'h3F, 1'b0);

      doReset("stream");
      runStreaming();

      doReset("midwin");
      for (int i = 0; i < 5; i++) applyStimulus(4'd6);
      doReset("abort");
      runWindow("after abort", 32'h9999_9999, 4'd9, 8'd8, 7'h6F, CONF_DP);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
